regfile_sb: RTL

Integer register file with write-pending scoreboard: the responder behind the decode stage's two register read ports and the sink of the writeback stage's write port. Holds 32 x 64-bit architectural registers, returns operands combinationally, and tracks up to three in-flight writes per register. Decode uses the busy flags to stall or select forwarded values.

---
 rtl/regfile_sb.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 32 x 64-bit integer register file with a per-register
// write-pending scoreboard (saturating 2-bit counters).
// Two combinational read ports, one writeback port, one issue port.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data onto the read ports and to clear busy for a retiring last write.
// Reset is asynchronous and active-low on the port named 'reset'.
module regfile_sb #(
    parameter int NREG  = 32,
    parameter int XLEN  = 64,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            issue_valid,
    input  logic [4:0]      issue_dst,
    output logic            issue_ready,
    input  logic            wvalid,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic            flush
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Entry 0 exists only to keep indexing uniform; it is never written.
    logic [XLEN-1:0]  regs [NREG];
    logic [CNT_W-1:0] cnt  [NREG];

    logic            retire;
    logic            issue_take;
    logic [NREG-1:0] inc_hit;
    logic [NREG-1:0] dec_hit;

    assign retire      = wvalid && (wa != '0);
    assign issue_ready = (issue_dst == '0) || (cnt[issue_dst] != CNT_MAX);
    assign issue_take  = issue_valid && (issue_dst != '0) && issue_ready;

    // Decode which register is being issued to and which is retiring.
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        if (issue_take) begin
            inc_hit[issue_dst] = 1'b1;
        end
        if (retire) begin
            dec_hit[wa] = 1'b1;
        end
    end

    // Architectural data: writeback always accepted, x0 writes dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (retire) begin
            regs[wa] <= wd;
        end
    end

    // Pending counters: issue and retire on the same register cancel;
    // a retire at zero leaves the counter at zero; flush clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc_hit[i] && !dec_hit[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_hit[i] && !inc_hit[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Read ports: registered state, optional forwarding, x0 forced to zero.
    always_comb begin
        rd1   = regs[ra1];
        busy1 = (cnt[ra1] != '0);
        rd2   = regs[ra2];
        busy2 = (cnt[ra2] != '0);
`ifdef REGFILE_BYPASS_EN
        if (retire && (wa == ra1)) begin
            rd1   = wd;
            busy1 = (cnt[ra1] > CNT_W'(1));
        end
        if (retire && (wa == ra2)) begin
            rd2   = wd;
            busy2 = (cnt[ra2] > CNT_W'(1));
        end
`else
`endif
        if (ra1 == '0) begin
            rd1   = '0;
            busy1 = 1'b0;
        end
        if (ra2 == '0) begin
            rd2   = '0;
            busy2 = 1'b0;
        end
    end

endmodule
